// File: rtl/mixcolumns_seq.sv
// Iterative forward AES MixColumns: transforms COLS_PER_CYCLE columns per clock
// behind valid/ready handshakes, holding the result until it is consumed.
module mixcolumns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned COL_W  = 32;
  localparam int unsigned NCOLS  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned STEPS  = (COLS_PER_CYCLE == 0) ? 1 : NCOLS / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [6:0]          col_lsb;

  // GF(2^8) multiply by 2 modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Next-state and working-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    col_lsb = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // column 0 sits in the top word, so column index maps to a descending lsb
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          col_lsb = 7'(COL_W * (NCOLS - 1 - (32'(cnt_q) * COLS_PER_CYCLE + j)));
          work_d[col_lsb +: COL_W] = mix_col(work_q[col_lsb +: COL_W]);
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      out_valid <= (state_d == DONE);
    end
  end

  assign out_data = work_q;
  assign busy     = (state_q == BUSY);
  // Blocked during reset so nothing is captured by a block that is being cleared
  assign in_ready = (state_q == IDLE) && !rst;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Bench for mixcolumns_seq: three instances (1, 2, 4 columns per cycle) checked
// every cycle against a GF(2^8) matrix model, plus literal vectors.
module tb_mixcolumns_seq;

  localparam int unsigned NI = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NI-1:0]          in_valid;
  logic [NI-1:0]          in_ready;
  logic [NI-1:0][127:0]   in_data;
  logic [NI-1:0]          out_valid;
  logic [NI-1:0]          out_ready;
  logic [NI-1:0][127:0]   out_data;
  logic [NI-1:0]          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model state: the DUT holds at most one block, so one pending slot each
  bit           pend_v  [NI];
  logic [127:0] pend_in [NI];
  logic [127:0] pend_x  [NI];
  int           pend_e  [NI];
  int           accepted[NI];
  int           produced[NI];
  int           hs1[NI], hs2[NI], hs3[NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mixcolumns_seq #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g])
    );
  end

  function automatic int nper(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
  endfunction

  // generic GF(2^8) product, shift-and-add
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // circulant matrix product per column; coefs holds the first matrix row
  function automatic logic [127:0] circ(input logic [127:0] s, input logic [31:0] coefs);
    logic [127:0] res = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
          acc = acc ^ gmul(s[127-32*c-8*i -: 8], coefs[31-8*((i - r + 4) % 4) -: 8]);
        end
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    return circ(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return circ(s, 32'h0e0b0d09);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare all instances against the model, then advance it for the next edge
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit exp_ov, exp_ir, exp_busy;
      exp_ov   = pend_v[k] && (cyc >= pend_e[k] + nper(k));
      exp_ir   = !rst && !pend_v[k];
      exp_busy = pend_v[k] && !exp_ov;
      check($sformatf("out_valid[%0d]", k), 128'(out_valid[k]), 128'(exp_ov));
      check($sformatf("in_ready[%0d]", k), 128'(in_ready[k]), 128'(exp_ir));
      check($sformatf("busy[%0d]", k), 128'(busy[k]), 128'(exp_busy));
      if (exp_ov) check($sformatf("out_data[%0d]", k), out_data[k], pend_x[k]);
      if (rst) begin
        pend_v[k] = 1'b0;
      end else if (exp_ov && out_ready[k]) begin
        check($sformatf("roundtrip[%0d]", k), inv_mix(out_data[k]), pend_in[k]);
        produced[k]++;
        hs3[k] = hs2[k];
        hs2[k] = hs1[k];
        hs1[k] = cyc + 1;
        pend_v[k] = 1'b0;
      end else if (!pend_v[k] && in_valid[k]) begin
        pend_v[k]  = 1'b1;
        pend_in[k] = in_data[k];
        pend_x[k]  = mix(in_data[k]);
        pend_e[k]  = cyc + 1;
        accepted[k]++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input int k, input logic [127:0] d);
    int t = 0;
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready[k]) break;
      t++;
      if (t > 200) begin
        note_fail($sformatf("send[%0d]", k));
        break;
      end
    end
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
  endtask

  // lat = edges from the accepting edge to the edge that raised out_valid
  task automatic wait_out(input int k, output logic [127:0] d, output int lat);
    int n = 0;
    d = '0;
    lat = -1;
    forever begin
      @(negedge clk);
      n++;
      if (out_valid[k]) begin
        d = out_data[k];
        lat = n - 1;
        break;
      end
      if (n > 50) begin
        note_fail($sformatf("wait_out[%0d]", k));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pop(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1 out_ready[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] V1    = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_X  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPSX = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V2    = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;
  localparam logic [127:0] V2_X  = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;

  initial begin
    logic [127:0] d, held;
    int lat, acc0, prod0;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;

    check("model_v1", mix(V1), V1_X);
    check("model_fips", mix(FIPS), FIPSX);
    check("model_inv", inv_mix(FIPSX), FIPS);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) check($sformatf("reset_out_data[%0d]", k), out_data[k], '0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(0, V1);
    wait_out(0, d, lat);
    check("v1_data", d, V1_X);
    check("v1_latency", 128'(lat), 128'(4));
    pop(0);

    for (int k = 0; k < NI; k++) begin
      send(k, FIPS);
      wait_out(k, d, lat);
      check($sformatf("fips_data[%0d]", k), d, FIPSX);
      check($sformatf("fips_latency[%0d]", k), 128'(lat), 128'(nper(k)));
      pop(k);
    end

    // backpressure with an extra input pulse that must be ignored
    send(0, {$urandom, $urandom, $urandom, $urandom});
    wait_out(0, held, lat);
    acc0  = accepted[0];
    prod0 = produced[0];
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
        in_valid[0] = 1'b1;
      end
      @(negedge clk);
      check("bp_valid", 128'(out_valid[0]), 128'(1));
      check("bp_data", out_data[0], held);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    pop(0);
    @(negedge clk);
    check("bp_after_valid", 128'(out_valid[0]), 128'(0));
    check("bp_after_ready", 128'(in_ready[0]), 128'(1));
    check("bp_accepts", 128'(accepted[0] - acc0), 128'(0));
    check("bp_handshakes", 128'(produced[0] - prod0), 128'(1));
    @(posedge clk);
    #1;

    // reset while BUSY with cnt=2
    send(0, {$urandom, $urandom, $urandom, $urandom});
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 128'(out_valid[0]), 128'(0));
    check("rst_mid_data", out_data[0], '0);
    @(posedge clk);
    #1;
    send(0, V2);
    wait_out(0, d, lat);
    check("v2_data", d, V2_X);
    pop(0);

    // random stream with stalls on both sides
    for (int k = 0; k < NI; k++) begin
      int a0, p0;
      a0 = accepted[k];
      p0 = produced[k];
      fork
        begin
          for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send(k, {$urandom, $urandom, $urandom, $urandom});
          end
        end
        begin
          int t = 0;
          while (produced[k] < p0 + 1000 && t < 20000) begin
            @(posedge clk);
            #1 out_ready[k] = ($urandom_range(0, 3) != 0);
            t++;
          end
          out_ready[k] = 1'b0;
          if (t >= 20000) note_fail($sformatf("random_drain[%0d]", k));
        end
      join
      check($sformatf("rand_accepted[%0d]", k), 128'(accepted[k] - a0), 128'(1000));
      check($sformatf("rand_produced[%0d]", k), 128'(produced[k] - p0), 128'(1000));
    end

    // back-to-back with out_ready tied high
    for (int k = 0; k < NI; k++) begin
      int p0, t;
      p0 = produced[k];
      out_ready[k] = 1'b1;
      for (int i = 0; i < 3; i++) send(k, {$urandom, $urandom, $urandom, $urandom});
      t = 0;
      while (produced[k] < p0 + 3 && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
      out_ready[k] = 1'b0;
      if (t >= 50) note_fail($sformatf("b2b_drain[%0d]", k));
      check($sformatf("b2b_gap_a[%0d]", k), 128'(hs2[k] - hs3[k]), 128'(nper(k) + 2));
      check($sformatf("b2b_gap_b[%0d]", k), 128'(hs1[k] - hs2[k]), 128'(nper(k) + 2));
      @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mixcolumns_seq.md
Name: mixcolumns_seq

Overview:
- Forward AES-128 MixColumns engine for the encryption datapath; the counterpart of the existing combinational inverse MixColumns stage.
- Iterative: processes COLS_PER_CYCLE 32-bit columns per clock.
- Valid/ready handshakes on both sides, so it sits between the ShiftRows and AddRoundKey stages of an iterative round loop.
- Holds its result until the downstream consumer accepts it.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is a compile-time error.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  128  state; column c = in_data[127-32c -: 32], row r byte = bits [127-32c-8r -: 8]
out_valid  output  1  out_data holds a completed result
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  128  MixColumns(in_data), same column/row packing as in_data
busy  output  1  high in BUSY state

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; column counter=0; out_valid=0; out_data=128'h0; working register=0.
  - in_ready=0 while rst is high.
  - Reset mid-operation aborts the transform silently; no partial output is ever presented.
- Define N = 4/COLS_PER_CYCLE.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1, busy=0, out_valid=0.
    - On an edge with in_valid=1: capture in_data into the working register, clear the counter, go to BUSY.
    - in_valid=0: stay in IDLE.
  - BUSY: in_ready=0, busy=1.
    - Each edge replaces columns [cnt*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1] of the working register with their transformed value; cnt increments.
    - On the edge that processes the last column (cnt=N-1), go to DONE with out_valid=1.
    - in_valid is ignored while in BUSY.
  - DONE: out_valid=1, out_data=working register, in_ready=0.
    - On an edge with out_ready=1, go to IDLE.
    - While out_ready=0, out_data and out_valid are held stable indefinitely.
- Latency: out_valid rises exactly N cycles after the accepting edge (4 / 2 / 1 cycles for COLS_PER_CYCLE 1 / 2 / 4).
- Throughput: one block per N+2 cycles when out_ready is tied high.
  - The return to IDLE costs 1 cycle; there is no accept in the same cycle as the output handshake.
- Column transform, with a0..a3 the row bytes:
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- GF(2^8) arithmetic:
  - 2x = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00)
  - 3x = 2x ^ x
  - All arithmetic is 8-bit; no carries between bytes.
- Column order and packing are identical to the inverse MixColumns stage, so that stage applied to out_data must return the original in_data.
- in_valid, out_ready and in_data may change arbitrarily outside handshake edges without effect.

Test Plan:
- Single column (COLS_PER_CYCLE=1): in_data columns {db135345, f20a225c, 01010101, c6c6c6c6} -> out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - out_valid rises 4 cycles after the accepting edge.
  - in_ready=0 throughout BUSY and DONE.
- FIPS-197 round-1 state d4bf5d30e0b452aeb84111f11e2798e5 -> 046681e5e0cb199a48f8d37a2806264c.
  - Run for COLS_PER_CYCLE=1, 2 and 4; latency must be 4, 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> out_data constant and out_valid stays 1.
  - A second in_valid pulse during this window is not accepted.
  - Raising out_ready gives exactly one handshake, then IDLE.
- Reset mid-operation: assert rst for one cycle at BUSY cnt=2 -> out_valid=0 and out_data=0 on the next cycle.
  - A new input 2d26314c_d4d4d4d5_00000000_ffffffff -> 4d7ebdf8_d5d5d7d6_00000000_ffffffff.
- Round-trip: 1000 random states through mixcolumns_seq, then through the inverse MixColumns stage -> output equals the original input every time.
  - Randomize in_valid and out_ready stalls; count accepted and produced transfers and check they are equal.
- Back-to-back with out_ready tied high: 3 consecutive inputs -> outputs in order, spaced exactly N+2 cycles apart.
